// File: rtl/video_filter_pr_swap_ctrl.sv
// Sequences a partial-reconfiguration swap of the video_filter RM aligned to frame boundaries.
// Latency: video in -> out is FILTER_LATENCY+1 cycles in both RM and bypass paths.
// Backpressure: none; the DVI stream free-runs and the bypass keeps it alive during a swap.
//
// Ports:
//   clk, reset                       pixel clock, async active-high reset
//   swap_req                         1-cycle request to swap the RM
//   pr_start / pr_done / pr_error    handshake with the PR bitstream loader
//   decouple, rm_reset               RM isolation (bypass select) and RM reset
//   busy, swap_err                   status: swap in progress / last swap failed (sticky)
//   active_pixel, hsync_in, vsync_in, r_in/g_in/b_in   incoming DVI stream
//   filt_r/g/b                       RM outputs, FILTER_LATENCY cycles behind r_in etc.
//   active_pixel_out, hsync_out, vsync_out, r_out/g_out/b_out   outgoing DVI stream
//
// Optional feature: define VIDEO_PR_TIMEOUT_EN to abort a LOAD that lasts TIMEOUT_CYCLES.

module video_filter_pr_swap_ctrl #(
    parameter int unsigned FILTER_LATENCY  = 2,
    parameter int unsigned RM_RESET_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 16777215
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       swap_req,
    input  logic       pr_done,
    input  logic       pr_error,
    input  logic       active_pixel,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [7:0] r_in,
    input  logic [7:0] g_in,
    input  logic [7:0] b_in,
    input  logic [7:0] filt_r,
    input  logic [7:0] filt_g,
    input  logic [7:0] filt_b,
    output logic       pr_start,
    output logic       decouple,
    output logic       rm_reset,
    output logic       busy,
    output logic       swap_err,
    output logic       active_pixel_out,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic [7:0] r_out,
    output logic [7:0] g_out,
    output logic [7:0] b_out
);

    // Elaboration-time sanity check on the configuration.
    if (FILTER_LATENCY < 1 || RM_RESET_CYCLES < 1 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 16777215) begin : g_param_check
        $error("video_filter_pr_swap_ctrl: parameter out of range");
    end

    localparam int unsigned HCW = (RM_RESET_CYCLES > 1) ? $clog2(RM_RESET_CYCLES) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(RM_RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FRAME,
        S_LOAD,
        S_HOLD_RST,
        S_WAIT_REL,
        S_ERROR
    } state_e;

    state_e         state_q;
    logic           pr_start_q;
    logic           decouple_q;
    logic           rm_reset_q;
    logic           busy_q;
    logic           swap_err_q;
    logic [HCW-1:0] hold_cnt_q;
    logic           vsync_prev_q;
    logic           vsync_rise;

`ifdef VIDEO_PR_TIMEOUT_EN
    localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CYCLES - 1);
    logic [23:0] to_cnt_q;
`endif

    assign vsync_rise = vsync_in & ~vsync_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_prev_q <= 1'b0;
        end else begin
            vsync_prev_q <= vsync_in;
        end
    end

    // Control FSM; all outputs are registered. decouple only ever toggles on
    // a vsync_rise cycle so the pixel mux switches during vertical blanking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pr_start_q <= 1'b0;
            decouple_q <= 1'b0;
            rm_reset_q <= 1'b1;
            busy_q     <= 1'b0;
            swap_err_q <= 1'b0;
            hold_cnt_q <= '0;
`ifdef VIDEO_PR_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
        end else begin
            pr_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Releases the power-on RM reset one cycle after reset deasserts.
                    rm_reset_q <= 1'b0;
                    if (swap_req) begin
                        state_q <= S_WAIT_FRAME;
                        busy_q  <= 1'b1;
                    end
                end
                S_WAIT_FRAME: begin
                    // decouple/rm_reset are left alone here: on a retry from
                    // ERROR they are already asserted and must stay that way.
                    if (vsync_rise) begin
                        state_q    <= S_LOAD;
                        decouple_q <= 1'b1;
                        rm_reset_q <= 1'b1;
                        pr_start_q <= 1'b1;
`ifdef VIDEO_PR_TIMEOUT_EN
                        to_cnt_q   <= '0;
`endif
                    end
                end
                S_LOAD: begin
                    if (pr_error) begin
                        state_q    <= S_ERROR;
                        swap_err_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else if (pr_done) begin
                        state_q    <= S_HOLD_RST;
                        hold_cnt_q <= '0;
`ifdef VIDEO_PR_TIMEOUT_EN
                    end else if (to_cnt_q == TO_LAST) begin
                        state_q    <= S_ERROR;
                        swap_err_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        to_cnt_q   <= to_cnt_q + 24'd1;
`endif
                    end
                end
                S_HOLD_RST: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_q    <= S_WAIT_REL;
                        rm_reset_q <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                S_WAIT_REL: begin
                    if (vsync_rise) begin
                        state_q    <= S_IDLE;
                        decouple_q <= 1'b0;
                        busy_q     <= 1'b0;
                        swap_err_q <= 1'b0;
                    end
                end
                S_ERROR: begin
                    if (swap_req) begin
                        state_q <= S_WAIT_FRAME;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Bypass delay line: {active_pixel, hsync, vsync, r, g, b}.
    logic [26:0] dly_q [FILTER_LATENCY];
    logic [26:0] out_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(FILTER_LATENCY); i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            dly_q[0] <= {active_pixel, hsync_in, vsync_in, r_in, g_in, b_in};
            for (int i = 1; i < int'(FILTER_LATENCY); i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    // Output register: sync always comes from the delay line so it stays
    // aligned regardless of which pixel source is selected.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= '0;
        end else if (decouple_q) begin
            out_q <= dly_q[FILTER_LATENCY-1];
        end else begin
            out_q <= {dly_q[FILTER_LATENCY-1][26:24], filt_r, filt_g, filt_b};
        end
    end

    assign pr_start         = pr_start_q;
    assign decouple         = decouple_q;
    assign rm_reset         = rm_reset_q;
    assign busy             = busy_q;
    assign swap_err         = swap_err_q;
    assign active_pixel_out = out_q[26];
    assign hsync_out        = out_q[25];
    assign vsync_out        = out_q[24];
    assign r_out            = out_q[23:16];
    assign g_out            = out_q[15:8];
    assign b_out            = out_q[7:0];

endmodule

// File: tb/tb_video_filter_pr_swap_ctrl.sv
// Directed bench for video_filter_pr_swap_ctrl with a pixel scoreboard.
// Latency: checks video outputs FILTER_LATENCY+1 cycles after each driven input.
// Backpressure: none; one stimulus cycle per tick.

module tb_video_filter_pr_swap_ctrl;

    localparam int L  = 2;
    localparam int RR = 16;
    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       swap_req, pr_done, pr_error;
    logic       active_pixel, hsync_in, vsync_in;
    logic [7:0] r_in, g_in, b_in, filt_r, filt_g, filt_b;
    logic       pr_start, decouple, rm_reset, busy, swap_err;
    logic       active_pixel_out, hsync_out, vsync_out;
    logic [7:0] r_out, g_out, b_out;

    int checks = 0;
    int errors = 0;
    int starts = 0;

    // Expected decouple during the current cycle, and after the next edge.
    logic exp_dec, exp_dec_nxt;

    logic [26:0] sb [$];
    logic [26:0] hist [L];

    always #5 clk = ~clk;

    video_filter_pr_swap_ctrl #(
        .FILTER_LATENCY (L),
        .RM_RESET_CYCLES(RR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .swap_req        (swap_req),
        .pr_done         (pr_done),
        .pr_error        (pr_error),
        .active_pixel    (active_pixel),
        .hsync_in        (hsync_in),
        .vsync_in        (vsync_in),
        .r_in            (r_in),
        .g_in            (g_in),
        .b_in            (b_in),
        .filt_r          (filt_r),
        .filt_g          (filt_g),
        .filt_b          (filt_b),
        .pr_start        (pr_start),
        .decouple        (decouple),
        .rm_reset        (rm_reset),
        .busy            (busy),
        .swap_err        (swap_err),
        .active_pixel_out(active_pixel_out),
        .hsync_out       (hsync_out),
        .vsync_out       (vsync_out),
        .r_out           (r_out),
        .g_out           (g_out),
        .b_out           (b_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: randomise pixels, model the RM (pixel ^ 0x91 after L
    // cycles), push the expected output, then compare after the edge.
    task automatic tick();
        logic [26:0] cur;
        logic [26:0] e;
        logic        dsel;
        active_pixel = 1'($urandom);
        hsync_in     = 1'($urandom);
        r_in         = 8'($urandom);
        g_in         = 8'($urandom);
        b_in         = 8'($urandom);
        filt_r       = hist[L-1][23:16] ^ 8'h91;
        filt_g       = hist[L-1][15:8]  ^ 8'h91;
        filt_b       = hist[L-1][7:0]   ^ 8'h91;
        cur  = {active_pixel, hsync_in, vsync_in, r_in, g_in, b_in};
        dsel = exp_dec;
        sb.push_back(cur);
        for (int k = L - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = cur;
        @(posedge clk);
        #1;
        swap_req = 1'b0;
        pr_done  = 1'b0;
        pr_error = 1'b0;
        exp_dec  = exp_dec_nxt;
        if (pr_start) starts++;
        chk("decouple", {31'd0, decouple}, {31'd0, exp_dec});
        if (sb.size() == L + 1) begin
            e = sb.pop_front();
            chk("video", {5'd0, active_pixel_out, hsync_out, vsync_out, r_out, g_out, b_out},
                {5'd0, dsel ? e : {e[26:24], e[23:0] ^ 24'h919191}});
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ctl"}, {27'd0, pr_start, decouple, rm_reset, busy, swap_err},
            {27'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        chk({tag, "_video"}, {5'd0, active_pixel_out, hsync_out, vsync_out, r_out, g_out, b_out}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        swap_req = 0; pr_done = 0; pr_error = 0;
        active_pixel = 0; hsync_in = 0; vsync_in = 0;
        r_in = 0; g_in = 0; b_in = 0; filt_r = 0; filt_g = 0; filt_b = 0;
        exp_dec = 0; exp_dec_nxt = 0;
        for (int k = 0; k < L; k++) hist[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        reset = 1'b0;
        tick();
        chk("rm_reset_release", {31'd0, rm_reset}, 32'd0);

        // T1: idle, filtered path selected with FILTER_LATENCY+1 latency.
        ticks(10);

        // T2: full swap.
        swap_req = 1'b1;
        tick();
        chk("t2_busy", {31'd0, busy}, 32'd1);
        ticks(5);
        chk("t2_wait_no_start", starts, 0);
        vsync_in = 1'b1; exp_dec_nxt = 1'b1;
        tick();
        chk("t2_pr_start", {31'd0, pr_start}, 32'd1);
        chk("t2_rm_reset", {31'd0, rm_reset}, 32'd1);
        ticks(3);
        vsync_in = 1'b0;
        ticks(20);
        chk("t2_one_start", starts, 1);
        pr_done = 1'b1;
        tick();
        ticks(RR - 1);
        chk("t2_hold_rm_reset", {31'd0, rm_reset}, 32'd1);
        tick();
        chk("t2_rm_reset_low", {31'd0, rm_reset}, 32'd0);
        ticks(5);
        chk("t2_busy_wait_rel", {31'd0, busy}, 32'd1);
        vsync_in = 1'b1; exp_dec_nxt = 1'b0;
        tick();
        chk("t2_done", {30'd0, busy, swap_err}, 32'd0);
        ticks(2);
        vsync_in = 1'b0;
        ticks(5);

        // T3: simultaneous pr_error/pr_done -> ERROR, then a successful retry.
        starts = 0;
        swap_req = 1'b1;
        tick();
        vsync_in = 1'b1; exp_dec_nxt = 1'b1;
        tick();
        vsync_in = 1'b0;
        ticks(4);
        pr_done = 1'b1; pr_error = 1'b1;
        tick();
        chk("t3_error", {29'd0, swap_err, busy, decouple, rm_reset}, {29'd0, 1'b1, 1'b0, 1'b1, 1'b1});
        ticks(3);
        vsync_in = 1'b1;
        ticks(2);
        vsync_in = 1'b0;
        ticks(3);
        chk("t3_error_held", {29'd0, swap_err, busy, decouple, rm_reset}, {29'd0, 1'b1, 1'b0, 1'b1, 1'b1});
        swap_req = 1'b1;
        tick();
        chk("t3_retry_busy", {30'd0, busy, swap_err}, {30'd0, 1'b1, 1'b1});
        ticks(3);
        vsync_in = 1'b1;
        tick();
        chk("t3_retry_start", {31'd0, pr_start}, 32'd1);
        vsync_in = 1'b0;
        ticks(4);
        pr_done = 1'b1;
        tick();
        ticks(RR + 2);
        vsync_in = 1'b1; exp_dec_nxt = 1'b0;
        tick();
        chk("t3_recovered", {29'd0, swap_err, busy, decouple, rm_reset}, 32'd0);
        chk("t3_starts", starts, 2);
        vsync_in = 1'b0;
        ticks(4);

        // T4: ignored inputs.
        starts = 0;
        pr_done = 1'b1;
        tick();
        chk("t4_done_idle", {29'd0, pr_start, busy, rm_reset, swap_err}, 32'd0);
        swap_req = 1'b1; vsync_in = 1'b1;
        tick();
        chk("t4_req_busy", {31'd0, busy}, 32'd1);
        ticks(3);
        vsync_in = 1'b0;
        tick();
        swap_req = 1'b1;
        tick();
        pr_done = 1'b1;
        tick();
        chk("t4_wait_no_start", starts, 0);
        chk("t4_wait_state", {30'd0, busy, rm_reset}, {30'd0, 1'b1, 1'b0});

        // T5: LOAD without any loader response.
        vsync_in = 1'b1; exp_dec_nxt = 1'b1;
        tick();
        vsync_in = 1'b0;
        swap_req = 1'b1;
`ifdef VIDEO_PR_TIMEOUT_EN
        ticks(TO - 1);
        chk("t5_before_timeout", {30'd0, busy, swap_err}, {30'd0, 1'b1, 1'b0});
        tick();
        chk("t5_timeout", {30'd0, busy, swap_err}, {30'd0, 1'b0, 1'b1});
        swap_req = 1'b1;
        tick();
        vsync_in = 1'b1;
        tick();
        vsync_in = 1'b0;
        ticks(3);
`else
        ticks(1000);
        chk("t5_still_load", {29'd0, busy, swap_err, decouple}, {29'd0, 1'b1, 1'b0, 1'b1});
`endif
        chk("t5_starts", starts, 1 + ((TO > 0) ? 0 : 1)
`ifdef VIDEO_PR_TIMEOUT_EN
            + 1
`endif
        );
        pr_done = 1'b1;
        tick();

        // T6: asynchronous reset in HOLD_RST.
        ticks(5);
        chk("t6_in_hold", {30'd0, busy, rm_reset}, {30'd0, 1'b1, 1'b1});
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("t6_async");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        exp_dec = 1'b0; exp_dec_nxt = 1'b0;
        tick();
        chk("t6_after", {29'd0, rm_reset, decouple, busy, swap_err}, 32'd0);
        ticks(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
